// File: rtl/fp32_pkg.sv
// fp32_pkg: IEEE-754 single-precision field constants, class codes and classifier.
package fp32_pkg;
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_FRAC_MSB = 22;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
  typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, QNAN, SNAN} fp_class_t;
  function automatic fp_class_t fp32_classify(input logic [31:0] v);
    logic [7:0] e;
    logic [22:0] f;
    e = v[FP32_EXP_MSB:FP32_EXP_LSB];
    f = v[FP32_FRAC_MSB:0];
    return e == 8'h00 ? (f == '0 ? ZERO : SUBN) :
           e != FP32_EXP_MAX ? NORM :
           f == '0 ? INF :
           f[FP32_FRAC_MSB] ? QNAN : SNAN;
  endfunction
endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: show-ahead synchronous FIFO with explicit level and synchronous flush.
module fp_sync_fifo #(
  parameter int W = 35,
  parameter int DEPTH = 8,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [W-1:0] mem_q [DEPTH];
  logic push, pop;
  assign in_ready = lvl_q != LW'(DEPTH);
  assign out_valid = lvl_q != '0;
  assign level = lvl_q;
  assign push = in_valid && in_ready && !clear;
  assign pop = out_valid && out_ready && !clear;
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign out_data = out_valid ? mem_q[rd_q] : '0;
  always_comb begin
    wr_d = clear ? '0 : wr_q + AW'(push);
    rd_d = clear ? '0 : rd_q + AW'(pop);
    lvl_d = clear ? '0 : lvl_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
  end
endmodule

// File: rtl/fp_result_buffer.sv
// fp_result_buffer: classifying fp32 result FIFO with statistics; FTZ via FP_RESULT_BUFFER_FTZ_EN.
module fp_result_buffer
  import fp32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_class,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] count,
  output logic             nan_seen
);
  fp_class_t cls;
  logic [34:0] entry, head;
  logic push;
  logic [CNT_W-1:0] count_q, count_d;
  logic nan_seen_q, nan_seen_d;
  always_comb begin
    cls = fp32_classify(in_result);
    entry = {3'(cls), in_result};
`ifdef FP_RESULT_BUFFER_FTZ_EN
    if (cls == SUBN) entry = {3'(ZERO), in_result[31], 31'b0};
`endif
  end
  assign push = in_valid && in_ready && !clear;
  always_comb begin
    count_d = clear ? '0 : count_q + CNT_W'(push);
    nan_seen_d = !clear && (nan_seen_q || (push && (cls == QNAN || cls == SNAN)));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      nan_seen_q <= 1'b0;
    end else begin
      count_q <= count_d;
      nan_seen_q <= nan_seen_d;
    end
  end
  fp_sync_fifo #(.W(35), .DEPTH(DEPTH), .LW(LVL_W)) u_fifo (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(entry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(head),
    .level(level)
  );
  assign out_result = head[31:0];
  assign out_class = head[34:32];
  assign count = count_q;
  assign nan_seen = nan_seen_q;
endmodule

// File: tb/tb_fp_result_buffer.sv
// tb_fp_result_buffer: table vectors plus scoreboard-checked sequences for fp_result_buffer.
module tb_fp_result_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LVL_W = 4;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_result = '0;
  logic in_ready, out_valid, nan_seen;
  logic [31:0] out_result;
  logic [2:0] out_class;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] count;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] v; logic [2:0] c;} ent_t;
  typedef struct {logic [31:0] v; logic [31:0] ev; logic [2:0] ec;} vec_t;
  ent_t sb[$];
  int m_cnt = 0;
  bit m_nan = 0;
  vec_t tbl[9];
  fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_class(out_class), .level(level), .count(count), .nan_seen(nan_seen)
  );
  always #5 clock = ~clock;
  function automatic ent_t expect_of(input logic [31:0] x);
    ent_t r;
    r.v = x;
    if (x[30:23] == 8'hFF) r.c = x[22:0] == 0 ? 3'd3 : x[22] ? 3'd4 : 3'd5;
    else if (x[30:23] != 8'h00) r.c = 3'd2;
    else if (x[22:0] == 0) r.c = 3'd0;
    else begin
`ifdef FP_RESULT_BUFFER_FTZ_EN
      r.v = {x[31], 31'b0};
      r.c = 3'd0;
`else
      r.c = 3'd1;
`endif
    end
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_state();
    chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("level", 64'(level), 64'(sb.size()));
    chk("count", 64'(count), 64'(16'(m_cnt)));
    chk("nan_seen", 64'(nan_seen), 64'(m_nan));
    chk("head_result", 64'(out_result), 64'(sb.size() != 0 ? sb[0].v : 32'h0));
    chk("head_class", 64'(out_class), 64'(sb.size() != 0 ? sb[0].c : 3'd0));
  endtask
  task automatic cyc();
    bit p, q;
    p = in_valid && sb.size() < DEPTH && !clear;
    q = out_ready && sb.size() > 0 && !clear;
    if (q) chk("pop_data", 64'({out_class, out_result}), 64'({sb[0].c, sb[0].v}));
    @(posedge clock);
    #1;
    if (clear) begin
      sb.delete();
      m_cnt = 0;
      m_nan = 0;
    end else begin
      if (q) void'(sb.pop_front());
      if (p) begin
        ent_t e;
        e = expect_of(in_result);
        sb.push_back(e);
        m_cnt++;
        if (e.c >= 3'd4) m_nan = 1;
      end
    end
    check_state();
  endtask
  task automatic drive(input logic [31:0] v, input logic iv, input logic orr, input logic clr);
    in_result = v;
    in_valid = iv;
    out_ready = orr;
    clear = clr;
    cyc();
  endtask
  initial begin
    int c0;
    tbl[0] = '{32'h3F800000, 32'h3F800000, 3'd2};
    tbl[1] = '{32'h00000000, 32'h00000000, 3'd0};
    tbl[2] = '{32'h80000000, 32'h80000000, 3'd0};
    tbl[3] = '{32'h7F800000, 32'h7F800000, 3'd3};
    tbl[4] = '{32'hFF800000, 32'hFF800000, 3'd3};
    tbl[5] = '{32'h7FC00000, 32'h7FC00000, 3'd4};
    tbl[6] = '{32'h7F800001, 32'h7F800001, 3'd5};
    tbl[7] = '{32'h00FFFFFF, 32'h00FFFFFF, 3'd2};
`ifdef FP_RESULT_BUFFER_FTZ_EN
    tbl[8] = '{32'h80000001, 32'h80000000, 3'd0};
`else
    tbl[8] = '{32'h80000001, 32'h80000001, 3'd1};
`endif
    #1;
    check_state();
    #6 reset = 1'b0;
    // Single result with out_ready high: visible next cycle, then drained.
    drive(32'h3F800000, 1, 1, 0);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_result", 64'(out_result), 64'h3F800000);
    chk("first_class", 64'(out_class), 64'd2);
    chk("first_count", 64'(count), 64'd1);
    drive(0, 0, 1, 0);
    chk("first_drained", 64'(level), 64'd0);
    foreach (tbl[i]) begin
      drive(tbl[i].v, 1, 0, 0);
      chk("tbl_result", 64'(out_result), 64'(tbl[i].ev));
      chk("tbl_class", 64'(out_class), 64'(tbl[i].ec));
      drive(0, 0, 1, 0);
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) drive(32'h40000000 + 32'(i), 1, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd8);
    drive(32'h41000000, 1, 1, 0);
    chk("refused_count", 64'(count), 64'd8);
    chk("refused_level", 64'(level), 64'd7);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(32'h42000000 + 32'(i), 1, 1, 0);
    chk("wrap_level", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    chk("drained", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 1);
    drive(32'h7FC00000, 1, 0, 0);
    drive(32'h7F800001, 1, 0, 0);
    chk("qnan_class", 64'(out_class), 64'd4);
    chk("nan_seen_set", 64'(nan_seen), 64'd1);
    drive(0, 0, 1, 0);
    chk("snan_class", 64'(out_class), 64'd5);
    drive(32'h3F800000, 1, 1, 1);
    chk("clear_nan", 64'(nan_seen), 64'd0);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) drive(32'h3F000000 + 32'(i), 1, 0, 0);
    c0 = int'(count);
    for (int i = 0; i < 10; i++) drive(32'hC0000000 + 32'(i), 1, 1, 0);
    chk("steady_level", 64'(level), 64'd3);
    chk("steady_count", 64'(count), 64'(c0 + 10));
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(32'h3E000000 + 32'(i), 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    m_cnt = 0;
    m_nan = 0;
    check_state();
    chk("async_level", 64'(level), 64'd0);
    #3 reset = 1'b0;
    drive(32'h12345678, 1, 0, 0);
    chk("post_reset_level", 64'(level), 64'd1);
    chk("post_reset_head", 64'(out_result), 64'h12345678);
    drive(0, 0, 1, 0);
    chk("post_reset_empty", 64'(out_valid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
- Capture stage between the floating-point MAC output and the result writer or host drain port.
- Buffers IEEE-754 single-precision results in a FIFO using a valid/ready handshake on both sides.
- Classifies each result when it is written and keeps running statistics.
- Decouples MAC throughput from drain stalls, so results are never dropped and never duplicated.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the accepted-result counter.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the FIFO and statistics.
- in_valid  in  1  MAC result valid.
- in_ready  out  1  buffer can accept a result.
- in_result  in  32  fp32 result from the MAC.
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream consumes the head entry.
- out_result  out  32  head fp32 value.
- out_class  out  3  class of the head entry.
- level  out  LVL_W  number of occupied entries, 0..DEPTH.
- count  out  CNT_W  total results accepted since reset or clear.
- nan_seen  out  1  sticky flag: any NaN has been accepted.

Behaviour:
- Clock is clock. Reset is reset: one clock, asynchronous, active-high.
- While reset is high, all storage pointers are 0. Outputs: in_ready=1, out_valid=0, out_result=0, out_class=0, level=0, count=0, nan_seen=0.
- Push occurs when in_valid && in_ready. in_ready = (level != DEPTH). in_ready is registered-state only and never depends on out_ready, so a full FIFO refuses a push even if a pop happens in the same cycle.
- Pop occurs when out_valid && out_ready. out_valid = (level != 0).
- The head is presented show-ahead: out_result and out_class are valid whenever out_valid=1 and hold stable until popped.
- Latency: a result pushed into an empty FIFO appears at the output the next cycle. There is no combinational in-to-out path.
- A simultaneous push and pop with 0 < level < DEPTH leaves level unchanged, and both operations occur.
- Pointers are log2(DEPTH) bits wide and wrap naturally. level is tracked explicitly, incremented on push and decremented on pop.
- Classification is computed at push time from exponent e[30:23] and fraction f[22:0], and stored as a 35-bit entry:
  - 0 = zero: e=0, f=0.
  - 1 = subnormal: e=0, f!=0.
  - 2 = normal.
  - 3 = inf: e=255, f=0.
  - 4 = qNaN: e=255, f[22]=1.
  - 5 = sNaN: e=255, f[22]=0, f!=0.
  - Codes 6 and 7 are never produced.
- count increments by 1 on every push and wraps modulo 2^CNT_W.
- nan_seen is set on the push of class 4 or 5 and stays set until reset or clear.
- clear has priority over push and pop in the same cycle. On the next edge: level=0, pointers=0, count=0, nan_seen=0. Any push presented in that cycle is discarded and is not counted.
- Reset asserted mid-stream discards all contents immediately.

Optional Feature:
- Macro: FP_RESULT_BUFFER_FTZ_EN.
- When defined, subnormal inputs are flushed on push: stored as {sign, 31'b0} with class 0 (zero).
- When undefined, subnormals are stored unmodified with class 1.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package fp32_pkg holds:
  - Constants: FP32_EXP_MSB=30, FP32_EXP_LSB=23, FP32_FRAC_MSB=22, FP32_EXP_MAX=8'hFF.
  - Typedef fp_class_t (3-bit enum: ZERO, SUBN, NORM, INF, QNAN, SNAN).
  - Classification function fp32_classify.
- One sub-module, fp_sync_fifo: parameterised width/depth storage plus pointers and level. The top level adds classification, statistics, clear and FTZ.

Test Plan:
- Reset, then push 32'h3F800000 (1.0) with out_ready=1. Expect out_valid=1 the next cycle, out_result=32'h3F800000, out_class=2, count=1, then level returns to 0.
- Push 8 values (DEPTH=8) with out_ready=0. Expect in_ready=0 and level=8; a 9th push is refused and count=8. Then drain with out_ready=1 and verify FIFO order, including pointer wrap after 4 additional push/pop pairs.
- Push 32'h7FC00000 then 32'h7F800001. Expect out_class 4 then 5 and nan_seen=1. Assert clear: nan_seen=0, count=0, out_valid=0.
- With level=3, push and pop together for 10 cycles. Expect level to stay at 3 and count to increase by 10.
- Push 32'h80000001. Without FTZ: out_result=32'h80000001, class 1. With FP_RESULT_BUFFER_FTZ_EN: out_result=32'h80000000, class 0.
- Assert reset mid-burst at level=5, asynchronously between edges. Expect all outputs to reach their reset values immediately; after release the next push appears as the only entry.
